// File: rtl/coef_pkg.sv
// Shared constants, FSM state and word-class enums for the coefficient FIFO loader.
package coef_pkg;

    localparam logic [7:0]  TAG_HDR    = 8'hA5;
    localparam logic [7:0]  TAG_DATA   = 8'h00;
    localparam logic [15:0] UNITY_GAIN = 16'h4000;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StPollWait,
        StRead,
        StReadWait
    } state_t;

    typedef enum logic [1:0] {
        WordHdrOk,
        WordHdrBad,
        WordData,
        WordBad
    } word_kind_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/coef_word_decode.sv
// Classifies one popped FIFO word as header, data or invalid, and splits out its fields.
module coef_word_decode
    import coef_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [31:0]       word,
    output word_kind_t        kind,
    output logic [7:0]        hdr_len,
    output logic [IDX_W-1:0]  ch_idx,
    output logic [COEF_W-1:0] gain
);

    localparam logic [7:0] MAX_N = 8'(NUM_CH);

    logic [7:0] tag;
    logic [7:0] ch;

    assign tag     = word[31:24];
    assign ch      = word[23:16];
    assign hdr_len = word[7:0];
    assign ch_idx  = ch[IDX_W-1:0];
    assign gain    = word[COEF_W-1:0];

    always_comb begin
        kind = WordBad;
        if (tag == TAG_HDR) begin
            kind = (hdr_len != 8'd0 && hdr_len <= MAX_N) ? WordHdrOk : WordHdrBad;
        end else if (tag == TAG_DATA) begin
            kind = (ch < MAX_N) ? WordData : WordBad;
        end
    end

endmodule

// File: rtl/coef_fifo_loader.sv
// Polls a coefficient FIFO, assembles framed gain updates in a shadow bank and
// commits them atomically to the active coefficient bank.
module coef_fifo_loader
    import coef_pkg::*;
#(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned POLL_CYC = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [2:0]               fifo_csr_address,
    output logic                     fifo_csr_read,
    input  logic [31:0]              fifo_csr_readdata,
    output logic                     fifo_out_read,
    input  logic [31:0]              fifo_out_readdata,
    output logic [NUM_CH*COEF_W-1:0] coef_bank,
    output logic                     coef_update,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(POLL_CYC + 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYC);

    state_t            state;
    logic [CNT_W-1:0]  poll_cnt;
    logic [7:0]        avail;
    logic              frame_open;
    logic [7:0]        remaining;
    logic [NUM_CH-1:0] mask;
    logic              commit;
    logic [COEF_W-1:0] shadow [NUM_CH];

    word_kind_t        kind;
    logic [7:0]        hdr_len;
    logic [IDX_W-1:0]  ch_idx;
    logic [COEF_W-1:0] gain;

    coef_word_decode #(
        .NUM_CH (NUM_CH),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W)
    ) u_decode (
        .word    (fifo_out_readdata),
        .kind    (kind),
        .hdr_len (hdr_len),
        .ch_idx  (ch_idx),
        .gain    (gain)
    );

    // Only the fill_level register is ever read.
    assign fifo_csr_address = 3'd0;
    assign busy             = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= StIdle;
            poll_cnt      <= '0;
            avail         <= '0;
            frame_open    <= 1'b0;
            remaining     <= '0;
            mask          <= '0;
            commit        <= 1'b0;
            fifo_csr_read <= 1'b0;
            fifo_out_read <= 1'b0;
            coef_update   <= 1'b0;
            err_count     <= '0;
            coef_bank     <= {NUM_CH{COEF_W'(UNITY_GAIN)}};
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k] <= COEF_W'(UNITY_GAIN);
            end
        end else begin
            fifo_csr_read <= 1'b0;
            fifo_out_read <= 1'b0;
            coef_update   <= 1'b0;

            // Commit lands one cycle after the last data word so its shadow write is visible.
            if (commit) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (mask[k]) begin
                        coef_bank[k*COEF_W +: COEF_W] <= shadow[k];
                    end
                end
                coef_update <= 1'b1;
                commit      <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (poll_cnt == POLL_LAST) begin
                        poll_cnt      <= '0;
                        fifo_csr_read <= 1'b1;
                        state         <= StPoll;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                StPoll: begin
                    state <= StPollWait;
                end
                StPollWait: begin
                    avail <= (fifo_csr_readdata > 32'd255) ? 8'hFF : fifo_csr_readdata[7:0];
                    if (fifo_csr_readdata == 32'd0) begin
                        state <= StIdle;
                    end else begin
                        fifo_out_read <= 1'b1;
                        state         <= StRead;
                    end
                end
                StRead: begin
                    avail <= avail - 8'd1;
                    state <= StReadWait;
                end
                StReadWait: begin
                    unique case (kind)
                        WordHdrOk: begin
                            if (frame_open) begin
                                err_count <= sat_inc(err_count);
                            end
                            frame_open <= 1'b1;
                            mask       <= '0;
                            remaining  <= hdr_len;
                        end
                        WordData: begin
                            if (frame_open) begin
                                shadow[ch_idx] <= gain;
                                mask[ch_idx]   <= 1'b1;
                                remaining      <= remaining - 8'd1;
                                if (remaining == 8'd1) begin
                                    frame_open <= 1'b0;
                                    commit     <= 1'b1;
                                end
                            end else begin
                                err_count <= sat_inc(err_count);
                            end
                        end
                        WordHdrBad, WordBad: begin
                            err_count  <= sat_inc(err_count);
                            frame_open <= 1'b0;
                        end
                    endcase
                    if (avail != 8'd0) begin
                        fifo_out_read <= 1'b1;
                        state         <= StRead;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
